// File: rtl/cpu_pkg.sv
// Shared definitions for the program-memory loader: loader FSM encoding, NOP word, memory geometry.
package cpu_pkg;

  localparam int unsigned DefDepth = 256;
  localparam int unsigned DefAw    = 8;

  localparam logic [31:0] Nop = 32'h0000_0000;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StHdr   = 3'd1,
    StBytes = 3'd2,
    StWrite = 3'd3,
    StDone  = 3'd4
  } ld_state_e;

endpackage

// File: rtl/load_byte_packer.sv
// Collects an MSB-first byte stream into 32-bit words; word_valid fires with the 4th byte.
module load_byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] shift_q, shift_d;

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (clear) begin
      cnt_d   = '0;
      shift_d = '0;
    end else if (byte_valid) begin
      cnt_d   = cnt_q + 2'd1;
      shift_d = {shift_q[15:0], byte_in};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  // The 4th byte is passed straight through so the word is ready in the same cycle.
  assign word_valid = byte_valid && !clear && (cnt_q == 2'd3);
  assign word       = {shift_q, byte_in};

endmodule

// File: rtl/imem_load_arbiter.sv
// Program-memory arbiter: CPU fetch owns the memory until a UART load stalls the CPU,
// streams words into memory and then requests a CPU restart.
module imem_load_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH   = DefDepth,
  parameter int unsigned AW      = DefAw,
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [30:0]   cpu_addr,
  output logic [31:0]   cpu_data,
  output logic          cpu_stall,
  output logic          cpu_rst_req,
  input  logic          ld_start,
  input  logic          ld_valid,
  input  logic [7:0]    ld_byte,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          mem_we,
  input  logic [31:0]   mem_rdata,
  output logic          load_busy,
  output logic          load_err
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  ld_state_e     state_q, state_d;
  logic [AW:0]   n_q, n_d;
  logic [AW-1:0] word_idx_q, word_idx_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;

  logic          pk_valid;
  logic [31:0]   pk_word;
  logic          timing;
  logic          accept;
  logic          tmo_hit;
  logic          last_word;
  logic          in_range;
  logic          unused_addr_lsb;

  assign unused_addr_lsb = ^cpu_addr[1:0];

  assign timing    = (state_q == StHdr) || (state_q == StBytes);
  assign accept    = ld_valid && (state_q inside {StHdr, StBytes, StWrite});
  assign tmo_hit   = timing && !ld_valid && (tmo_q == TW'(TIMEOUT - 1));
  assign last_word = (({1'b0, word_idx_q} + (AW + 1)'(1)) == n_q);
  assign in_range  = ({3'b000, cpu_addr[30:2]} < DEPTH);

  load_byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (state_q == StIdle),
    .byte_valid (ld_valid && ((state_q == StBytes) || (state_q == StWrite))),
    .byte_in    (ld_byte),
    .word_valid (pk_valid),
    .word       (pk_word)
  );

  // State register and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      n_q        <= '0;
      word_idx_q <= '0;
      wdata_q    <= '0;
      tmo_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      word_idx_q <= word_idx_d;
      wdata_q    <= wdata_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (ld_start) state_d = StHdr;
      StHdr: begin
        if (tmo_hit)       state_d = StIdle;
        else if (ld_valid) state_d = StBytes;
      end
      StBytes: begin
        if (tmo_hit)       state_d = StIdle;
        else if (pk_valid) state_d = StWrite;
      end
      StWrite: state_d = last_word ? StDone : StBytes;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    n_d        = n_q;
    word_idx_d = word_idx_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    tmo_d      = '0;

    if (state_q == StHdr && ld_valid) begin
      // A count of zero means a full-memory load.
      n_d        = (ld_byte == 8'd0) ? (AW + 1)'(DEPTH) : (AW + 1)'(ld_byte);
      word_idx_d = '0;
    end
    if (state_q == StBytes && pk_valid) wdata_d = pk_word;
    if (state_q == StWrite) word_idx_d = word_idx_q + AW'(1);

    if (timing && !accept) tmo_d = tmo_q + TW'(1);

    if (tmo_hit) err_d = 1'b1;
    else if (state_q == StIdle && ld_start) err_d = 1'b0;
  end

  // Outputs
  always_comb begin
    cpu_stall   = (state_q != StIdle);
    load_busy   = (state_q != StIdle);
    cpu_rst_req = (state_q == StDone);
    mem_we      = (state_q == StWrite);
    mem_wdata   = wdata_q;
    mem_addr    = word_idx_q;
    cpu_data    = Nop;
    load_err    = err_q;
    if (state_q == StIdle) begin
      mem_addr = cpu_addr[AW+1:2];
      if (in_range) cpu_data = mem_rdata;
    end
  end

endmodule

// File: tb/tb_imem_load_arbiter.sv
// Directed bench for imem_load_arbiter: fetch table plus hand-written load, timeout and reset sequences.
module tb_imem_load_arbiter;

  localparam int unsigned TMO = 40;

  logic        clk = 1'b0;
  logic        reset;
  logic [30:0] cpu_addr;
  logic [31:0] cpu_data;
  logic        cpu_stall, cpu_rst_req;
  logic        ld_start, ld_valid;
  logic [7:0]  ld_byte;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;
  logic        load_busy, load_err;

  logic [31:0] mem [256];
  logic [7:0]  wr_addr [$];
  logic [31:0] wr_data [$];
  int          rst_pulses = 0;
  int          stall_gaps = 0;
  int          nop_bad = 0;

  int n_checks = 0;
  int n_errors = 0;

  imem_load_arbiter #(.DEPTH(256), .AW(8), .TIMEOUT(TMO)) dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_addr    (cpu_addr),
    .cpu_data    (cpu_data),
    .cpu_stall   (cpu_stall),
    .cpu_rst_req (cpu_rst_req),
    .ld_start    (ld_start),
    .ld_valid    (ld_valid),
    .ld_byte     (ld_byte),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .mem_rdata   (mem_rdata),
    .load_busy   (load_busy),
    .load_err    (load_err)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
    end
    if (cpu_rst_req) rst_pulses <= rst_pulses + 1;
    if (load_busy && !cpu_stall) stall_gaps <= stall_gaps + 1;
    if (cpu_stall && cpu_data != 32'h0) nop_bad <= nop_bad + 1;
  end

  typedef struct {
    logic [30:0] addr;
    logic [31:0] data;
  } fvec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    ld_valid = 1'b1;
    ld_byte  = b;
    tick();
    ld_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    send_byte(w[31:24], gap);
    send_byte(w[23:16], gap);
    send_byte(w[15:8], gap);
    send_byte(w[7:0], gap);
  endtask

  task automatic start_load();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max);
    bit ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (!load_busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check(name, 32'(ok), 32'd1);
  endtask

  function automatic logic [31:0] fw(input int i);
    logic [7:0] b = 8'(i);
    return {b, ~b, 8'h5A, b ^ 8'h3C};
  endfunction

  initial begin
    fvec_t       fv[7];
    int          p0;
    int          bad;
    logic [31:0] w;

    fv[0] = '{addr: 31'h10,       data: 32'hA500_0004};
    fv[1] = '{addr: 31'h400,      data: 32'h0};
    fv[2] = '{addr: 31'h0,        data: 32'hA500_0000};
    fv[3] = '{addr: 31'h3FC,      data: 32'hA500_00FF};
    fv[4] = '{addr: 31'h13,       data: 32'hA500_0004};
    fv[5] = '{addr: 31'h7FFF_FFFC, data: 32'h0};
    fv[6] = '{addr: 31'h401,      data: 32'h0};

    for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | 32'(i);

    reset    = 1'b0;
    cpu_addr = '0;
    ld_start = 1'b0;
    ld_valid = 1'b0;
    ld_byte  = '0;
    tick();
    tick();
    check("rst_stall", 32'(cpu_stall), 0);
    check("rst_rst_req", 32'(cpu_rst_req), 0);
    check("rst_we", 32'(mem_we), 0);
    check("rst_busy", 32'(load_busy), 0);
    check("rst_err", 32'(load_err), 0);
    reset = 1'b1;
    tick();

    // Fetch passthrough
    foreach (fv[i]) begin
      cpu_addr = fv[i].addr;
      #1;
      check($sformatf("fetch_data[%0d]", i), cpu_data, fv[i].data);
      check($sformatf("fetch_stall[%0d]", i), 32'(cpu_stall), 0);
    end
    cpu_addr = 31'h10;

    // Two-word load with idle gaps; a stray ld_start mid-load must be ignored
    wr_addr.delete(); wr_data.delete();
    p0 = rst_pulses;
    start_load();
    check("hdr_busy", 32'(load_busy), 1);
    check("hdr_nop", cpu_data, 32'h0);
    send_byte(8'h02, 1);
    send_word(32'h2008_003F, 1);
    start_load();
    send_word(32'hAC08_0000, 1);
    wait_idle("two_word_done", 10);
    tick();
    check("two_word_nwr", 32'(wr_addr.size()), 2);
    if (wr_addr.size() == 2) begin
      check("two_word_a0", 32'(wr_addr[0]), 0);
      check("two_word_d0", wr_data[0], 32'h2008_003F);
      check("two_word_a1", 32'(wr_addr[1]), 1);
      check("two_word_d1", wr_data[1], 32'hAC08_0000);
    end
    check("two_word_pulse", 32'(rst_pulses - p0), 1);
    check("two_word_busy", 32'(load_busy), 0);
    cpu_addr = 31'h4;
    #1;
    check("two_word_fetch", cpu_data, 32'hAC08_0000);

    // Back-to-back bytes; ld_valid together with ld_start is dropped
    wr_addr.delete(); wr_data.delete();
    p0 = rst_pulses;
    ld_valid = 1'b1;
    ld_byte  = 8'hFF;
    start_load();
    ld_valid = 1'b0;
    send_byte(8'h03, 0);
    send_word(32'h1122_3344, 0);
    send_word(32'h5566_7788, 0);
    send_word(32'h99AA_BBCC, 0);
    wait_idle("b2b_done", 10);
    check("b2b_nwr", 32'(wr_addr.size()), 3);
    if (wr_addr.size() == 3) begin
      check("b2b_d0", wr_data[0], 32'h1122_3344);
      check("b2b_d1", wr_data[1], 32'h5566_7788);
      check("b2b_d2", wr_data[2], 32'h99AA_BBCC);
      check("b2b_a2", 32'(wr_addr[2]), 2);
    end
    check("b2b_pulse", 32'(rst_pulses - p0), 1);

    // Full load: count 0 means 256 words
    wr_addr.delete(); wr_data.delete();
    p0 = rst_pulses;
    start_load();
    send_byte(8'h00, 0);
    for (int i = 0; i < 256; i++) begin
      w = fw(i);
      send_word(w, 0);
    end
    wait_idle("full_done", 10);
    check("full_nwr", 32'(wr_addr.size()), 256);
    bad = 0;
    for (int i = 0; i < wr_addr.size() && i < 256; i++) begin
      if (wr_addr[i] !== 8'(i) || wr_data[i] !== fw(i)) bad++;
    end
    check("full_bad_words", 32'(bad), 0);
    check("full_pulse", 32'(rst_pulses - p0), 1);

    // Timeout after 1.5 words of a 3-word load
    wr_addr.delete(); wr_data.delete();
    p0 = rst_pulses;
    start_load();
    send_byte(8'h03, 0);
    send_word(32'hDEAD_BEEF, 0);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    repeat (TMO - 1) tick();
    check("tmo_not_early", 32'(load_busy), 1);
    tick();
    check("tmo_idle", 32'(load_busy), 0);
    check("tmo_err", 32'(load_err), 1);
    check("tmo_stall", 32'(cpu_stall), 0);
    check("tmo_nwr", 32'(wr_addr.size()), 1);
    if (wr_addr.size() == 1) check("tmo_d0", wr_data[0], 32'hDEAD_BEEF);
    check("tmo_no_pulse", 32'(rst_pulses - p0), 0);
    start_load();
    check("tmo_err_clear", 32'(load_err), 0);

    // Reset mid-load (in BYTES)
    send_byte(8'h01, 0);
    send_byte(8'h77, 0);
    send_byte(8'h66, 0);
    cpu_addr = 31'h400;
    reset = 1'b0;
    #1;
    check("mid_rst_stall", 32'(cpu_stall), 0);
    check("mid_rst_busy", 32'(load_busy), 0);
    check("mid_rst_we", 32'(mem_we), 0);
    check("mid_rst_req", 32'(cpu_rst_req), 0);
    check("mid_rst_err", 32'(load_err), 0);
    check("mid_rst_data", cpu_data, 32'h0);
    tick();
    reset = 1'b1;
    tick();
    wr_addr.delete(); wr_data.delete();
    cpu_addr = 31'h8;
    #1;
    check("post_rst_fetch", cpu_data, fw(2));
    send_byte(8'h55, 3);
    check("stray_no_write", 32'(wr_addr.size()), 0);
    check("stray_busy", 32'(load_busy), 0);

    check("stall_gaps", 32'(stall_gaps), 0);
    check("nop_while_stalled", 32'(nop_bad), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
